// File: rtl/ysyx_24090018_mdu_pkg.sv
// Shared constants for the iterative M-extension unit: funct3 decode, FSM encodings, funct7.
package ysyx_24090018_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

endpackage

// File: rtl/ysyx_24090018_mdu_iter.sv
// One combinational step of the MDU: shift-add (multiply) or compare-subtract-shift (divide)
// on the {acc, op} pair.
module ysyx_24090018_mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] op_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] op_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum    = {1'b0, acc_i} + (op_i[0] ? {1'b0, b_i} : '0);
    rem_sh = {acc_i, op_i[XLEN-1]};
    // Remainder stays below the divisor, so the low XLEN bits of the difference suffice.
    diff   = rem_sh[XLEN-1:0] - b_i;
    ge     = (rem_sh >= {1'b0, b_i});
    if (is_div_i) begin
      acc_o = ge ? diff : rem_sh[XLEN-1:0];
      op_o  = {op_i[XLEN-2:0], ge};
    end else begin
      acc_o = sum[XLEN:1];
      op_o  = {sum[0], op_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ysyx_24090018_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit, one bit per cycle, valid/ready on both sides.
// Holds the FSM, iteration counter, operand sign handling and the divide fast path.
module ysyx_24090018_mdu
  import ysyx_24090018_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned     CNT_W  = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] acc_q, acc_d, op_q, op_d, b_q, b_d, result_q, result_d;

  logic            a_signed, b_signed, a_neg, b_neg, accept, div_zero, div_ovf;
  logic [XLEN-1:0] a_abs, b_abs, fast_res, iter_acc, iter_op, q_fix, r_fix, final_res;
  logic [2*XLEN-1:0] prod_fix;

  ysyx_24090018_mdu_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .is_div_i(funct3_q[2]),
    .acc_i   (acc_q),
    .op_i    (op_q),
    .b_i     (b_q),
    .acc_o   (iter_acc),
    .op_o    (iter_op)
  );

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign result_o    = result_q;

  always_comb begin
    a_signed = funct3_i inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    b_signed = funct3_i inside {MDU_MULH, MDU_DIV, MDU_REM};
    a_neg    = a_signed & src1_i[XLEN-1];
    b_neg    = b_signed & src2_i[XLEN-1];
    a_abs    = a_neg ? -src1_i : src1_i;
    b_abs    = b_neg ? -src2_i : src2_i;
    accept   = in_valid_i & in_ready_o & ~flush_i;
    div_zero = funct3_i[2] & (src2_i == '0);
    div_ovf  = (funct3_i inside {MDU_DIV, MDU_REM}) & (src1_i == MinInt) & (src2_i == '1);
    if (div_zero) fast_res = funct3_i[1] ? src1_i : '1;
    else          fast_res = funct3_i[1] ? '0 : src1_i;
  end

  // Sign fixup applied to the final iteration's output on the CALC->DONE edge.
  always_comb begin
    prod_fix = neg_q ? -{iter_acc, iter_op} : {iter_acc, iter_op};
    q_fix    = neg_q ? -iter_op : iter_op;
    r_fix    = rneg_q ? -iter_acc : iter_acc;
    if (funct3_q[2])             final_res = funct3_q[1] ? r_fix : q_fix;
    else if (funct3_q == MDU_MUL) final_res = prod_fix[XLEN-1:0];
    else                          final_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    op_d     = op_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          funct3_d = funct3_i;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          cnt_d    = '0;
          acc_d    = '0;
          op_d     = funct3_i[2] ? a_abs : b_abs;
          b_d      = funct3_i[2] ? b_abs : a_abs;
          if (div_zero || div_ovf) begin
            state_d  = StDone;
            result_d = fast_res;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = iter_acc;
        op_d  = iter_op;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d  = StDone;
          result_d = final_res;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      funct3_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24090018_mdu.sv
// Self-checking bench for ysyx_24090018_mdu: directed vector table, random ops against a
// behavioural model, and hand-written DONE-hold, flush and async-reset sequences.
module tb_ysyx_24090018_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  ysyx_24090018_mdu #(
    .XLEN(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .funct3_i   (funct3),
    .src1_i     (src1),
    .src2_i     (src2),
    .flush_i    (flush),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa = $signed({{32{a[31]}}, a});
    logic signed [63:0] sb = $signed({{32{b[31]}}, b});
    logic signed [63:0] ub = $signed({32'b0, b});
    logic        [63:0] ua = {32'b0, a};
    logic        [63:0] p;
    logic signed [31:0] q;
    logic               ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        q = $signed(a) / $signed(b); return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = $signed(a) % $signed(b); return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Drive one request, wait for its result, optionally hold out_ready low, then release.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold);
    int lat;
    int el;
    logic [31:0] e;
    logic [31:0] r0;
    @(negedge clk);
    check("in_ready_before_req", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; funct3 = f; src1 = a; src2 = b;
    exp_q.push_back(exp);
    lat_q.push_back(is_fast(f, a, b) ? 1 : 33);
    @(posedge clk); #1;
    in_valid = 1'b0; funct3 = 3'($urandom); src1 = $urandom; src2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      check("latency", 32'(lat), 32'(el));
      check("result", result, e);
    end
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_result", result, r0);
      check("hold_not_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_take", {31'b0, in_ready}, 32'd1);
    check("valid_drop", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;

    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    tbl[2]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    tbl[3]  = '{3'd3, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    tbl[8]  = '{3'd4, 32'd1234,       32'd0,         32'hFFFF_FFFF};
    tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
    tbl[12] = '{3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF};
    tbl[13] = '{3'd7, 32'd9,          32'd0,         32'd9};

    #1;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, 0);

    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = (i % 6 == 5) ? 32'd0 : ((i % 3 == 1) ? 32'($urandom_range(1, 255)) : $urandom);
      run_op(rf, ra, rb, model(rf, ra, rb), 0);
    end

    // Consumer stalls for 5 cycles in DONE.
    run_op(3'd0, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 5);

    // Flush at iteration 10 with a competing request in the same cycle.
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd5; src1 = 32'd1000; src2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; funct3 = 3'd0; src1 = 32'd2; src2 = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", {31'b0, in_ready}, 32'd1);
    check("flush_no_valid", {31'b0, out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen++;
    end
    check("flush_no_result", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of CALC; result_q holds a nonzero earlier result.
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd1; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
